// File: rtl/network_sequencer.sv
// Sequences one inference through the bitstream network: latch inputs, clear the
// stochastic state, run a fixed stream window, strobe capture, return the result.
module network_sequencer #(
    parameter int INPUT_SIZE     = 2,
    parameter int OUTPUT_SIZE    = 1,
    parameter int STREAM_LEN     = 256,
    parameter int RESULT_LATENCY = 1
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic signed [31:0] req_data [INPUT_SIZE],
    input  logic               abort,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic signed [31:0] resp_data [OUTPUT_SIZE],
    output logic               busy,
    output logic               net_n_rst,
    output logic signed [31:0] net_input [INPUT_SIZE],
    output logic               net_compute,
    input  logic signed [31:0] net_output [OUTPUT_SIZE]
);

    if (STREAM_LEN < 1) begin : g_bad_stream_len
        $error("network_sequencer: STREAM_LEN must be >= 1");
    end
    if (RESULT_LATENCY < 1) begin : g_bad_result_latency
        $error("network_sequencer: RESULT_LATENCY must be >= 1");
    end

    localparam int MAX_CNT = (STREAM_LEN > RESULT_LATENCY) ? STREAM_LEN : RESULT_LATENCY;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(STREAM_LEN - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RESULT_LATENCY - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_RUN     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_WAIT    = 3'd4,
        ST_RESP    = 3'd5
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic               flush_r;
    logic               flush_nxt_s;
    logic               accept_s;
    logic               capture_s;
    logic signed [31:0] net_input_r [INPUT_SIZE];
    logic signed [31:0] resp_data_r [OUTPUT_SIZE];

    // Next-state, counter and load-enable decode; abort overrides every other transition.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        flush_nxt_s = 1'b0;
        accept_s    = 1'b0;
        capture_s   = 1'b0;
        if (abort && (state_r != ST_IDLE)) begin
            // Flush: one CLEAR cycle flagged so that it falls back to IDLE.
            state_nxt_s = ST_CLEAR;
            cnt_nxt_s   = {CNT_W{1'b0}};
            flush_nxt_s = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        accept_s    = 1'b1;
                        state_nxt_s = ST_CLEAR;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    cnt_nxt_s = {CNT_W{1'b0}};
                    if (flush_r) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cnt_r == RUN_LAST) begin
                        state_nxt_s = ST_CAPTURE;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_nxt_s   = cnt_r + CNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end
                ST_WAIT: begin
                    if (cnt_r == WAIT_LAST) begin
                        capture_s   = 1'b1;
                        state_nxt_s = ST_RESP;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_nxt_s   = cnt_r + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_RESP;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // State, window counter and flush flag registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            flush_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            flush_r <= flush_nxt_s;
        end
    end

    // Network inputs: loaded on acceptance only, held across responses and aborts.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < INPUT_SIZE; i++) begin
                net_input_r[i] <= 32'sd0;
            end
        end else if (accept_s) begin
            for (int i = 0; i < INPUT_SIZE; i++) begin
                net_input_r[i] <= req_data[i];
            end
        end
    end

    // Result capture on the last WAIT cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < OUTPUT_SIZE; i++) begin
                resp_data_r[i] <= 32'sd0;
            end
        end else if (capture_s) begin
            for (int i = 0; i < OUTPUT_SIZE; i++) begin
                resp_data_r[i] <= net_output[i];
            end
        end
    end

    // Global reset also holds the network in reset.
    assign net_n_rst   = n_rst & (state_r != ST_CLEAR);
    assign req_ready   = (state_r == ST_IDLE);
    assign busy        = (state_r != ST_IDLE);
    assign resp_valid  = (state_r == ST_RESP);
    assign net_compute = (state_r == ST_CAPTURE);
    assign net_input   = net_input_r;
    assign resp_data   = resp_data_r;

endmodule

// File: tb/tb_network_sequencer.sv
// Self-checking bench for network_sequencer: cycle-accurate timeline checks plus
// a scoreboard of expected results against a stand-in network model.
module tb_network_sequencer;

    localparam int SL = 16;
    localparam int RL = 1;

    logic               clk;
    logic               n_rst;
    logic               req_valid;
    logic               req_ready;
    logic signed [31:0] req_data [2];
    logic               abort;
    logic               resp_valid;
    logic               resp_ready;
    logic signed [31:0] resp_data [1];
    logic               busy;
    logic               net_n_rst;
    logic signed [31:0] net_input [2];
    logic               net_compute;
    logic signed [31:0] net_output [1];

    logic [RL-1:0]      cap_q;
    logic signed [31:0] sb_q [$];
    int                 checks;
    int                 failures;
    int                 resp_cnt;

    network_sequencer #(
        .INPUT_SIZE     (2),
        .OUTPUT_SIZE    (1),
        .STREAM_LEN     (SL),
        .RESULT_LATENCY (RL)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data    (req_data),
        .abort       (abort),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .busy        (busy),
        .net_n_rst   (net_n_rst),
        .net_input   (net_input),
        .net_compute (net_compute),
        .net_output  (net_output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic signed [31:0] model_f(input logic signed [31:0] a,
                                                   input logic signed [31:0] b);
        return (a * b * 32'sd4) + 32'sd1;
    endfunction

    // Stand-in network: output is valid only RL cycles after the capture strobe.
    always_ff @(posedge clk or negedge net_n_rst) begin
        if (!net_n_rst) cap_q <= '0;
        else            cap_q <= (cap_q << 1) | RL'(net_compute);
    end
    assign net_output[0] = cap_q[RL-1] ? model_f(net_input[0], net_input[1]) : 32'sh5EAD_BEEF;

    task automatic check_val(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        check_val("rst_req_ready",   32'(req_ready),   32'sd1);
        check_val("rst_busy",        32'(busy),        32'sd0);
        check_val("rst_resp_valid",  32'(resp_valid),  32'sd0);
        check_val("rst_resp_data",   resp_data[0],     32'sd0);
        check_val("rst_net_input0",  net_input[0],     32'sd0);
        check_val("rst_net_input1",  net_input[1],     32'sd0);
        check_val("rst_net_compute", 32'(net_compute), 32'sd0);
        check_val("rst_net_n_rst",   32'(net_n_rst),   32'sd0);
    endtask

    // Full request from an IDLE cycle: hold = RESP cycles with resp_ready low,
    // noisy = keep req_valid high with fresh data, abort_at_resp = abort with handshake.
    task automatic run_req(input logic signed [31:0] d0, input logic signed [31:0] d1,
                           input int hold, input bit noisy, input bit abort_at_resp);
        int resp_c;
        resp_c = SL + 3 + RL;
        check_val("idle_req_ready", 32'(req_ready), 32'sd1);
        req_valid   = 1'b1;
        req_data[0] = d0;
        req_data[1] = d1;
        sb_q.push_back(model_f(d0, d1));
        for (int c = 1; c <= resp_c + hold; c++) begin
            step();
            req_valid  = noisy;
            resp_ready = 1'b0;
            if (noisy) begin
                req_data[0] = $urandom;
                req_data[1] = $urandom;
            end
            check_val("net_n_rst",   32'(net_n_rst),   32'(c != 1));
            check_val("net_compute", 32'(net_compute), 32'(c == SL + 2));
            check_val("busy",        32'(busy),        32'sd1);
            check_val("req_ready",   32'(req_ready),   32'sd0);
            check_val("resp_valid",  32'(resp_valid),  32'(c >= resp_c));
            check_val("net_input0",  net_input[0],     d0);
            check_val("net_input1",  net_input[1],     d1);
            if (c >= resp_c) check_val("resp_hold", resp_data[0], sb_q[0]);
        end
        resp_ready = 1'b1;
        abort      = abort_at_resp;
        if (abort_at_resp) begin
            sb_q.delete(0);
        end else begin
            check_val("resp_data", resp_data[0], sb_q.pop_front());
            resp_cnt++;
        end
        step();
        resp_ready = 1'b0;
        abort      = 1'b0;
        if (abort_at_resp) begin
            check_val("abort_flush_n_rst",  32'(net_n_rst),  32'sd0);
            check_val("abort_flush_rvalid", 32'(resp_valid), 32'sd0);
            step();
        end
        check_val("post_busy",       32'(busy),       32'sd0);
        check_val("post_req_ready",  32'(req_ready),  32'sd1);
        check_val("post_resp_valid", 32'(resp_valid), 32'sd0);
        check_val("post_net_n_rst",  32'(net_n_rst),  32'sd1);
        check_val("post_net_input0", net_input[0],    d0);
        check_val("post_net_input1", net_input[1],    d1);
    endtask

    initial begin
        int compute_seen;
        int rvalid_seen;
        int nrst_low_seen;
        checks      = 0;
        failures    = 0;
        resp_cnt    = 0;
        n_rst       = 1'b0;
        req_valid   = 1'b0;
        resp_ready  = 1'b0;
        abort       = 1'b0;
        req_data[0] = 32'sd0;
        req_data[1] = 32'sd0;
        #2;
        check_reset_values();
        step();
        step();
        n_rst = 1'b1;
        step();
        check_val("release_req_ready", 32'(req_ready), 32'sd1);
        check_val("release_net_n_rst", 32'(net_n_rst), 32'sd1);

        run_req(32'sd3, 32'sd7, 0, 1'b0, 1'b0);
        run_req(-32'sd20, 32'sd41, 5, 1'b1, 1'b0);
        run_req(32'sd1000, -32'sd3, 0, 1'b0, 1'b0);

        // Abort during the run window.
        req_valid   = 1'b1;
        req_data[0] = 32'sd5;
        req_data[1] = 32'sd9;
        sb_q.push_back(model_f(32'sd5, 32'sd9));
        for (int c = 1; c <= 6; c++) begin
            step();
            req_valid = 1'b0;
            check_val("ab_net_n_rst", 32'(net_n_rst), 32'(c != 1));
            check_val("ab_busy",      32'(busy),      32'sd1);
        end
        abort = 1'b1;
        sb_q.delete(0);
        step();
        abort = 1'b0;
        check_val("ab_flush_n_rst",   32'(net_n_rst),   32'sd0);
        check_val("ab_flush_compute", 32'(net_compute), 32'sd0);
        check_val("ab_flush_rvalid",  32'(resp_valid),  32'sd0);
        step();
        check_val("ab_idle_busy",   32'(busy),      32'sd0);
        check_val("ab_idle_ready",  32'(req_ready), 32'sd1);
        check_val("ab_idle_n_rst",  32'(net_n_rst), 32'sd1);
        check_val("ab_idle_input0", net_input[0],   32'sd5);
        check_val("ab_idle_input1", net_input[1],   32'sd9);
        compute_seen  = 0;
        rvalid_seen   = 0;
        nrst_low_seen = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (net_compute) compute_seen++;
            if (resp_valid)  rvalid_seen++;
            if (!net_n_rst)  nrst_low_seen++;
        end
        check_val("ab_no_compute",  compute_seen,  32'sd0);
        check_val("ab_no_rvalid",   rvalid_seen,   32'sd0);
        check_val("ab_no_nrst_low", nrst_low_seen, 32'sd0);
        run_req(32'sd6, 32'sd6, 0, 1'b0, 1'b0);

        run_req(32'sd2, 32'sd8, 1, 1'b0, 1'b1);

        // Asynchronous reset in the middle of the run window.
        req_valid   = 1'b1;
        req_data[0] = 32'sd11;
        req_data[1] = 32'sd13;
        sb_q.push_back(model_f(32'sd11, 32'sd13));
        for (int c = 1; c <= 11; c++) begin
            step();
            req_valid = 1'b0;
        end
        check_val("ar_busy_before", 32'(busy), 32'sd1);
        #2;
        n_rst = 1'b0;
        sb_q.delete();
        #1;
        check_reset_values();
        step();
        step();
        n_rst = 1'b1;
        step();
        run_req(-32'sd4, 32'sd100000, 0, 1'b0, 1'b0);

        check_val("sb_empty",   sb_q.size(), 32'sd0);
        check_val("resp_count", resp_cnt,    32'sd5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/network_sequencer.md
# network_sequencer

Control stage directly upstream of the bitstream network: accepts one inference request over a valid/ready handshake, drives integer inputs into the network and holds them, clears the network's stochastic state, runs the bitstreams for a fixed window, and pulses the network's capture input. It then returns the captured integer outputs over a second valid/ready handshake. One inference is in flight at a time.

## Interface
- INPUT_SIZE, 2, number of network inputs.
- OUTPUT_SIZE, 1, number of network outputs.
- STREAM_LEN, 256, bitstream cycles per inference. Must be ≥1; elaboration error otherwise.
- RESULT_LATENCY, 1, cycles from the capture pulse to a valid network output. Must be ≥1; elaboration error otherwise.
- clk  in  1  single clock, rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_data  in  int[0:INPUT_SIZE-1]  input values for the request.
- abort  in  1  synchronous cancel of the in-flight inference.
- resp_valid  out  1  result present.
- resp_ready  in  1  consumer takes the result.
- resp_data  out  int[0:OUTPUT_SIZE-1]  captured network outputs.
- busy  out  1  high in every state except IDLE.
- net_n_rst  out  1  network reset, active-low.
- net_input  out  int[0:INPUT_SIZE-1]  network input values.
- net_compute  out  1  network capture strobe.
- net_output  in  int[0:OUTPUT_SIZE-1]  network output values.

## Operation
- FSM states: IDLE, CLEAR, RUN, CAPTURE, WAIT, RESP. All outputs are decoded from registered state or held in registers.
- IDLE: req_ready=1. When req_valid&req_ready at an edge, latch req_data into net_input and go to CLEAR.
- CLEAR: one cycle with net_n_rst=0. Next state is RUN with the counter at 0.
- RUN: stays for exactly STREAM_LEN cycles. Counter width is $clog2(STREAM_LEN+1). Next state is CAPTURE.
- CAPTURE: one cycle with net_compute=1. Next state is WAIT with the counter at 0.
- WAIT: stays for RESULT_LATENCY cycles. On the edge leaving WAIT, register net_output into resp_data and go to RESP.
- RESP: resp_valid=1. resp_data stays stable until resp_valid&resp_ready at an edge, then go to IDLE.
- net_n_rst = n_rst AND (state != CLEAR). This is the only combinational path from n_rst, so the network also resets during global reset.
- net_input holds its value from acceptance until the next acceptance. It is not cleared after a response or an abort.
- abort while busy: go to IDLE at the next edge and pulse net_n_rst low for one cycle (a CLEAR-equivalent cycle, then IDLE). No response is produced, and a pending resp_valid is dropped. abort in IDLE is ignored. abort has priority over every other transition, including a resp handshake in the same cycle.
- req_valid outside IDLE is ignored. req_ready is low, so there is no implicit queuing.
- The sequencer performs no arithmetic on data. Values pass through unchanged at full int width.

## Timing
- Reset values: state IDLE, req_ready=1, busy=0, resp_valid=0, resp_data all 0, net_input all 0, net_compute=0, net_n_rst=0 while n_rst is low.
- Cycles are numbered from acceptance edge E0:
  - CLEAR is cycle 1.
  - RUN is cycles 2..STREAM_LEN+1.
  - CAPTURE is cycle STREAM_LEN+2.
  - WAIT is cycles STREAM_LEN+3..STREAM_LEN+2+RESULT_LATENCY.
  - resp_valid first rises in cycle STREAM_LEN+3+RESULT_LATENCY.
- resp_data equals net_output as sampled during the last WAIT cycle.
- Minimum request spacing is STREAM_LEN+RESULT_LATENCY+4 cycles. There is one IDLE cycle after each response handshake.
- Asynchronous reset mid-operation: immediate return to reset values. No response.

## Test plan
- Reset: assert n_rst low mid-cycle -> all outputs at reset values without waiting for a clock edge. net_n_rst=0. After release, req_ready=1.
- Nominal, STREAM_LEN=16, RESULT_LATENCY=1, req_data={3,7}, model net_output=85 -> net_input={3,7} from cycle 1. net_n_rst=0 only in cycle 1. A single net_compute pulse in cycle 18. resp_valid from cycle 20, resp_data={85}. busy high in cycles 1..20.
- Backpressure: hold resp_ready=0 for 5 cycles, with req_valid=1 and new data throughout -> resp_valid and resp_data stable, req_ready=0, no second acceptance. Accept occurs one cycle after the resp handshake.
- Input hold: change req_data every cycle after acceptance -> net_input keeps the accepted values through RESP and after return to IDLE.
- Abort in RUN cycle 5 -> net_n_rst=0 for one cycle, then IDLE. No net_compute. resp_valid stays 0. A later request completes normally. Abort together with a resp handshake -> abort wins, one net_n_rst pulse.
- Async reset in RUN cycle 10 -> immediate reset values. A fresh request afterwards produces net_compute exactly in cycle STREAM_LEN+2.
